// File: rtl/led_scan_driver.sv
// led_scan_driver
//   Time-multiplexed driver for an N-digit 7-segment display that shares one segment bus.
//   Each digit holds a 5-bit code (bit4 = decimal point, bits3:0 = hex glyph). Digits are
//   scanned round-robin; the first BLANK_CYC cycles of every digit slot drive the segments
//   off so the previous digit's pattern cannot ghost onto the newly enabled digit.
//   New codes are loaded into a pending buffer and copied to the display buffer only at a
//   frame boundary, so a frame never shows a mix of old and new codes.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high; overrides every other input
//   en            scan enable; 0 = display dark, scan counters held at 0
//   load          strobe: capture codes_in / blank_in into the pending buffer
//   codes_in      digit i code at [5i+4:5i]; digit 0 is the rightmost
//   blank_in      1 = digit i dark (segments off, enable inactive)
//   o_seg         {dp,g,f,e,d,c,b,a}, registered, polarity per SEG_ACT_LOW
//   o_dig_en      one-hot digit enable, registered, polarity per SEL_ACT_LOW
//   o_frame_done  1-cycle pulse on the last output cycle of digit N_DIGITS-1's slot

module led_scan_driver #(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 4,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          SEL_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [5*N_DIGITS-1:0] codes_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [7:0]            o_seg,
    output logic [N_DIGITS-1:0]   o_dig_en,
    output logic                  o_frame_done
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]    DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Pin value for "everything off"; XOR with it converts active-high form to pin polarity.
    localparam logic [7:0]          SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_OFF   = SEL_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // Glyph table, active-high {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
        logic [6:0] g;
        g = 7'h00;
        case (hex)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;

    logic [5*N_DIGITS-1:0] pend_codes_q, pend_codes_d;
    logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;

    logic [5*N_DIGITS-1:0] disp_codes_q, disp_codes_d;
    logic [N_DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic div_wrap;
    logic frame_end;

    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign frame_end = en && div_wrap && (dig_idx_q == IDX_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        dig_idx_d = dig_idx_q;
        if (!en) begin
            // Held at zero so a rising en restarts at digit 0, slot cycle 0.
            div_cnt_d = '0;
            dig_idx_d = '0;
        end else if (div_wrap) begin
            div_cnt_d = '0;
            dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / display buffers
    // ------------------------------------------------------------------
    logic commit;

    // While the scan is stopped there is no frame to tear, so commit right away.
    assign commit = (frame_end || !en) && (pend_valid_q || load);

    always_comb begin
        pend_codes_d = pend_codes_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        disp_codes_d = disp_codes_q;
        disp_blank_d = disp_blank_q;

        if (load) begin
            pend_codes_d = codes_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end

        if (commit) begin
            // A load coinciding with the commit point bypasses the pending buffer.
            disp_codes_d = load ? codes_in : pend_codes_q;
            disp_blank_d = load ? blank_in : pend_blank_q;
            pend_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Current slot selection
    // ------------------------------------------------------------------
    logic [4:0]          cur_code;
    logic                cur_blank;
    logic [N_DIGITS-1:0] dig_onehot;

    always_comb begin
        cur_code   = '0;
        cur_blank  = 1'b0;
        dig_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig_idx_q == IDX_W'(i)) begin
                cur_code      = disp_codes_q[5*i +: 5];
                cur_blank     = disp_blank_q[i];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output next-state (active-high form, then pin polarity)
    // ------------------------------------------------------------------
    logic [7:0]          seg_ah;
    logic [N_DIGITS-1:0] dig_ah;

    always_comb begin
        seg_ah = 8'h00;
        dig_ah = '0;
        if (en && !cur_blank) begin
            dig_ah = dig_onehot;
            // Segments stay dark during the anti-ghosting window at the start of each slot.
            if (div_cnt_q >= BLANK_END) begin
                seg_ah = {cur_code[4], hex_glyph(cur_code[3:0])};
            end
        end
    end

    always_comb begin
        seg_d        = seg_ah ^ SEG_OFF;
        dig_en_d     = dig_ah ^ SEL_OFF;
        frame_done_d = frame_end;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            dig_idx_q    <= '0;
            pend_codes_q <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_codes_q <= '0;
            disp_blank_q <= '0;
            seg_q        <= SEG_OFF;
            dig_en_q     <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_idx_q    <= dig_idx_d;
            pend_codes_q <= pend_codes_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            disp_codes_q <= disp_codes_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_dig_en     = dig_en_q;
    assign o_frame_done = frame_done_q;

endmodule
